// File: rtl/ooo_read_responder.sv
// Out-of-order AXI-style read responder with a small slot table.
// Define RESP_REORDER_EN for expiry-order return; default is strict in-order.
module ooo_read_responder #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int BASE_LAT   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            s_arid_i,
   input  logic [ADDR_WIDTH-1:0] s_araddr_i,
   input  logic                  s_arvalid_i,
   output logic                  s_arready_o,
   output logic [DATA_WIDTH-1:0] s_rdata_o,
   output logic [3:0]            s_rid_o,
   output logic                  s_rvalid_o,
   input  logic                  s_rready_i
);

   localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int AGW = $clog2(DEPTH + 1);
   localparam int CW  = $clog2(BASE_LAT + 4);

   logic                  v_q    [DEPTH];
   logic                  v_d    [DEPTH];
   logic [3:0]            id_q   [DEPTH];
   logic [3:0]            id_d   [DEPTH];
   logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
   logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
   logic [AGW-1:0]        age_q  [DEPTH];
   logic [AGW-1:0]        age_d  [DEPTH];
   logic [CW-1:0]         cnt_q  [DEPTH];
   logic [CW-1:0]         cnt_d  [DEPTH];
`ifdef RESP_REORDER_EN
   logic [2:0]            ovd_q  [DEPTH];
   logic [2:0]            ovd_d  [DEPTH];
`endif

   logic [AGW-1:0]        occ_q, occ_d;
   logic                  rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [3:0]            rid_q, rid_d;

   logic                  free_found;
   logic [IW-1:0]         free_idx;
   logic                  sel_found;
   logic [IW-1:0]         sel_idx;
   logic [AGW-1:0]        sel_age;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_ext;
   logic                  acc;
   logic                  load;
   logic [CW-1:0]         new_cnt;
   logic [AGW-1:0]        new_age;

   assign s_arready_o = free_found;
   assign s_rvalid_o  = rvalid_q;
   assign s_rdata_o   = rdata_q;
   assign s_rid_o     = rid_q;

   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!v_q[i]) begin
            free_found = 1'b1;
            free_idx   = IW'(i);
         end
      end
   end

`ifdef RESP_REORDER_EN
   // Longest-expired wins, ties to oldest; a slot waits behind any older same-ID slot.
   always_comb begin
      logic       blk;
      logic [2:0] best_ovd;
      logic [AGW-1:0] best_age;
      blk       = 1'b0;
      best_ovd  = '0;
      best_age  = '0;
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         blk = 1'b0;
         for (int j = 0; j < DEPTH; j++) begin
            if (v_q[j] && id_q[j] == id_q[i] && age_q[j] < age_q[i])
               blk = 1'b1;
         end
         if (v_q[i] && cnt_q[i] == '0 && !blk) begin
            if (!sel_found || ovd_q[i] > best_ovd ||
                (ovd_q[i] == best_ovd && age_q[i] < best_age)) begin
               sel_found = 1'b1;
               sel_idx   = IW'(i);
               best_ovd  = ovd_q[i];
               best_age  = age_q[i];
            end
         end
      end
   end
`else
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (v_q[i] && age_q[i] == '0 && cnt_q[i] == '0) begin
            sel_found = 1'b1;
            sel_idx   = IW'(i);
         end
      end
   end
`endif

   assign sel_age  = age_q[sel_idx];
   assign sel_addr = addr_q[sel_idx];

   generate
      if (DATA_WIDTH > ADDR_WIDTH) begin : g_ext
         assign sel_ext = {{(DATA_WIDTH - ADDR_WIDTH){1'b0}}, sel_addr};
      end else begin : g_trunc
         assign sel_ext = sel_addr[DATA_WIDTH-1:0];
      end
   endgenerate

   assign acc     = s_arvalid_i && free_found;
   assign load    = sel_found && (!rvalid_q || s_rready_i);
   assign new_cnt = CW'(BASE_LAT) + CW'(s_araddr_i[1:0]);
   // Age is the rank among pending slots: 0 is the oldest.
   assign new_age = occ_q - AGW'(load);

   always_comb begin
      occ_d = occ_q + AGW'(acc) - AGW'(load);
      for (int i = 0; i < DEPTH; i++) begin
         v_d[i]    = v_q[i];
         id_d[i]   = id_q[i];
         addr_d[i] = addr_q[i];
         age_d[i]  = age_q[i];
         cnt_d[i]  = cnt_q[i];
`ifdef RESP_REORDER_EN
         ovd_d[i]  = ovd_q[i];
         if (v_q[i] && cnt_q[i] == '0 && ovd_q[i] != 3'd7)
            ovd_d[i] = ovd_q[i] + 3'd1;
`endif
         if (v_q[i] && cnt_q[i] != '0)
            cnt_d[i] = cnt_q[i] - CW'(1);
         if (load && v_q[i] && age_q[i] > sel_age)
            age_d[i] = age_q[i] - AGW'(1);
         if (load && IW'(i) == sel_idx) begin
            v_d[i]   = 1'b0;
            cnt_d[i] = '0;
`ifdef RESP_REORDER_EN
            ovd_d[i] = '0;
`endif
         end
         if (acc && IW'(i) == free_idx) begin
            v_d[i]    = 1'b1;
            id_d[i]   = s_arid_i;
            addr_d[i] = s_araddr_i;
            age_d[i]  = new_age;
            cnt_d[i]  = new_cnt;
`ifdef RESP_REORDER_EN
            ovd_d[i]  = '0;
`endif
         end
      end
   end

   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rid_d    = rid_q;
      if (!rvalid_q || s_rready_i) begin
         rvalid_d = sel_found;
         if (sel_found) begin
            rdata_d = ~sel_ext;
            rid_d   = id_q[sel_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q    <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rid_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            v_q[i]    <= 1'b0;
            id_q[i]   <= '0;
            addr_q[i] <= '0;
            age_q[i]  <= '0;
            cnt_q[i]  <= '0;
`ifdef RESP_REORDER_EN
            ovd_q[i]  <= '0;
`endif
         end
      end else begin
         occ_q    <= occ_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rid_q    <= rid_d;
         for (int i = 0; i < DEPTH; i++) begin
            v_q[i]    <= v_d[i];
            id_q[i]   <= id_d[i];
            addr_q[i] <= addr_d[i];
            age_q[i]  <= age_d[i];
            cnt_q[i]  <= cnt_d[i];
`ifdef RESP_REORDER_EN
            ovd_q[i]  <= ovd_d[i];
`endif
         end
      end
   end

endmodule

// File: doc/ooo_read_responder.md
OOO_READ_RESPONDER -- requirements
Module: ooo_read_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 8: R data width.
REQ-002 Parameter ADDR_WIDTH, default 8: AR address width.
REQ-003 Parameter DEPTH, default 4: max pending reads held in the slot table.
REQ-004 Parameter BASE_LAT, default 2: minimum service delay in cycles.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 s_arid_i  input  4  read transaction ID.
REQ-008 s_araddr_i  input  ADDR_WIDTH  read address.
REQ-009 s_arvalid_i  input  1  AR request valid.
REQ-010 s_arready_o  output  1  AR accept ready.
REQ-011 s_rdata_o  output  DATA_WIDTH  read data.
REQ-012 s_rid_o  output  4  ID of returned data.
REQ-013 s_rvalid_o  output  1  R response valid.
REQ-014 s_rready_i  input  1  R response ready.

Function
REQ-015 AR handshake SHALL complete on an edge with s_arvalid_i and s_arready_o high; s_arready_o SHALL be high iff at least one slot is free, derived from registered slot state only.
REQ-016 Accepted AR SHALL occupy the lowest-index free slot, storing ID, address, allocation age, and countdown L = BASE_LAT + s_araddr_i[1:0].
REQ-017 Each occupied slot countdown SHALL decrement by 1 per edge after acceptance, saturating at 0; a slot with countdown 0 is eligible.
REQ-018 The R output register SHALL load from the selected eligible slot on an edge where s_rvalid_o is low or s_rready_i is high; that slot SHALL be freed on the same edge.
REQ-019 Loaded data SHALL be s_rdata_o = bitwise inverse of the stored address zero-extended or truncated to DATA_WIDTH; s_rid_o = stored ID.
REQ-020 With no stall, AR accepted at edge N SHALL produce s_rvalid_o high after edge N+L+1.
REQ-021 While s_rvalid_o high and s_rready_i low, s_rvalid_o, s_rdata_o, s_rid_o SHALL hold stable.
REQ-022 On R handshake with no eligible slot, s_rvalid_o SHALL drop after that edge; with an eligible slot, the next response SHALL load back-to-back.
REQ-023 AR accept and slot release on the same edge SHALL both take effect; the released slot SHALL NOT be reused on that edge.
REQ-024 Full table (DEPTH occupied) SHALL hold s_arready_o low until a slot releases; the freed slot's s_arready_o SHALL rise after the releasing edge.
REQ-025 Duplicate IDs among pending slots SHALL be permitted; same-ID responses SHALL return in acceptance order in both configurations.

Reset
REQ-026 With rst high at an edge: all slots free, countdowns 0, age counter 0, s_rvalid_o 0, s_rdata_o 0, s_rid_o 0; s_arready_o 1 after the edge.
REQ-027 Reset mid-operation SHALL discard all pending and in-output responses without emitting them.

Configuration
REQ-028 Macro RESP_REORDER_EN defined: selection SHALL pick the eligible slot with the lowest countdown-expiry order, ties broken by oldest age, except REQ-025 same-ID constraint.
REQ-029 RESP_REORDER_EN undefined: selection SHALL consider only the oldest occupied slot, loading it only when eligible (strict in-order return, head-of-line blocking).

Verification
REQ-030 Single read: reset, AR id=2 addr=0x01 at edge N, rready=1 -> rvalid high after edge N+4 (L=3), rid=2, rdata=0xFE, one beat.
REQ-031 Reorder: AR id=2 addr=0x03 (L=5) then id=3 addr=0x00 (L=2) next edge -> macro on: id=3 rdata=0xFF then id=2 rdata=0xFC; macro off: id=2 then id=3.
REQ-032 Backpressure: response pending, rready=0 for 5 cycles -> rvalid, rid, rdata stable all 5 cycles; after rready=1 one handshake, next response back-to-back if eligible.
REQ-033 Full: DEPTH=4, four ARs accepted, rready=0 -> arready low, fifth AR (id=6) stalls; rready=1 -> fifth accepted the cycle after first release.
REQ-034 Same-ID: AR id=5 addr=0x03 then id=5 addr=0x00, macro on -> rdata 0xFC returned before 0xFF.
REQ-035 Reset mid-op: three pending, rst high one edge -> rvalid 0, arready 1, no stale response over the next 10 cycles.
